br_redirect: RTL and testbench
==============================

Name: br_redirect

Overview:
- Sits directly downstream of the branch reservation station's branch-resolution output (br_cdb).
- Captures the oldest mispredicted branch reported by the branch FU and holds it until the ROB commits that branch.
- On commit, issues a one-cycle pipeline flush plus a fetch redirect to the resolved target.
- Also forwards every resolved branch, one cycle later, as a predictor-update packet.

Parameters:
- ROB_DEPTH, 16, number of ROB entries; power of two.
- ROB_IDX_W, $clog2(ROB_DEPTH), ROB id width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- br_valid  in  1  branch result valid (br_cdb)
- br_rob_id  in  ROB_IDX_W  ROB id of resolved branch
- br_miss_predict  in  1  prediction was wrong (direction or target)
- br_target_address  in  32  correct next PC
- br_pc  in  32  PC of the branch
- br_taken  in  1  actual direction
- rob_head_id  in  ROB_IDX_W  ROB id at the head
- rob_commit_valid  in  1  head entry commits this cycle
- flush  out  1  one-cycle squash of all in-flight uops; fetch redirect
- redirect_pc  out  32  fetch target; meaningful only while flush=1
- pending  out  1  a mispredict is held, awaiting commit
- upd_valid  out  1  predictor update valid
- upd_pc  out  32  predictor update: branch PC
- upd_taken  out  1  predictor update: actual direction
- upd_target  out  32  predictor update: resolved target

Behaviour:
- Reset values:
  - flush=0, pending=0, upd_valid=0.
  - redirect_pc, upd_pc, upd_target = 0; upd_taken = 0.
  - FSM enters IDLE; held entry cleared.
- Age: age(id) = (id - rob_head_id) mod ROB_DEPTH, computed in ROB_IDX_W bits with natural wrap. Smaller age is older.
- FSM states:
  - IDLE: on br_valid && br_miss_predict, latch rob_id and target, then go to WAIT. Otherwise stay.
  - WAIT (pending=1):
    - If rob_commit_valid && rob_head_id == held_id, go to FLUSH.
    - Else if br_valid && br_miss_predict && age(br_rob_id) < age(held_id), replace the held entry with the new one.
    - A younger or equal-age mispredict is ignored.
  - FLUSH: flush=1 and redirect_pc=held target for exactly one cycle. Held entry cleared, pending=0. Next state is always IDLE.
- Latency:
  - Mispredict accepted in cycle N: pending=1 in N+1.
  - Commit handshake of the held id in cycle M: flush=1 in M+1.
  - Minimum mispredict-to-flush latency is 2 cycles (commit in the cycle after capture).
- Simultaneous events:
  - In WAIT, commit of the held id plus a new mispredict in the same cycle: commit wins, the new result is discarded (it is younger by construction).
  - In FLUSH, any br_valid input is discarded; it belongs to the squashed path.
  - In IDLE, a mispredict plus a commit of that same rob_id in the same cycle: capture only, go to WAIT. The ROB never commits an unresolved branch, so this case is illegal stimulus and carries no further requirement.
- Predictor update:
  - Any br_valid in IDLE or WAIT (mispredicted or not) registers upd_* and pulses upd_valid=1 for one cycle, in cycle N+1.
  - Discarded in FLUSH (upd_valid=0 in the following cycle).
- Wrap-around: age arithmetic must be correct when the held id is numerically smaller than rob_head_id (e.g. head=14, held=1 gives age 3).
- Reset mid-operation (WAIT or FLUSH): the next cycle is IDLE with pending=0, flush=0, upd_valid=0. No flush is emitted for the dropped entry.
- No backpressure: inputs are never stalled; the block accepts at most one branch result per cycle.

Test Plan:
- Reset, then hold inputs idle for 5 cycles -> flush=0, pending=0, upd_valid=0 throughout.
- Correct prediction: br_valid, rob_id=3, miss=0, pc=0x100, taken=1, target=0x200 -> next cycle upd_valid=1, upd_pc=0x100, upd_taken=1, upd_target=0x200; pending stays 0, no flush.
- Basic mispredict: rob_id=2, miss=1, target=0x0000_ffff, head=0. Commit ids 0, 1, 2 on consecutive cycles -> pending=1 from the capture cycle+1. flush=1 with redirect_pc=0x0000_ffff exactly one cycle after id 2 commits. Next cycle flush=0, pending=0.
- Older replaces younger: head=0. Mispredict id=5 (target 0x500), then mispredict id=3 (target 0x300). Commit up to id 3 -> flush with redirect_pc=0x300, in the cycle after id 3 commits. A later mispredict id=7 in WAIT is ignored.
- Wrap-around: head=14, held id=1 (target 0x40), then mispredict id=15 (target 0x80) -> replaced (age 1 < age 3). Flush with redirect_pc=0x80 after id 15 commits.
- Simultaneous commit and new result: held id=4, head=4. Same cycle: commit of id 4 and mispredict id=6 -> next cycle flush=1, redirect_pc=held target. The following cycle is IDLE with pending=0 and upd_valid=0.
- Reset during WAIT -> next cycle pending=0. No flush is emitted for the dropped entry, even when rob_commit_valid && rob_head_id == the dropped id.

Source files
------------

// File: rtl/br_redirect.sv
// Branch redirect unit: holds the oldest mispredicted branch until the ROB commits it,
// then emits a one-cycle flush with the fetch redirect. Forwards every branch result as a predictor update.
module br_redirect #(
  parameter int ROB_DEPTH = 16,
  parameter int ROB_IDX_W = $clog2(ROB_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 br_valid,
  input  logic [ROB_IDX_W-1:0] br_rob_id,
  input  logic                 br_miss_predict,
  input  logic [31:0]          br_target_address,
  input  logic [31:0]          br_pc,
  input  logic                 br_taken,
  input  logic [ROB_IDX_W-1:0] rob_head_id,
  input  logic                 rob_commit_valid,
  output logic                 flush,
  output logic [31:0]          redirect_pc,
  output logic                 pending,
  output logic                 upd_valid,
  output logic [31:0]          upd_pc,
  output logic                 upd_taken,
  output logic [31:0]          upd_target,
  output logic [1:0]           dbg_state
);

  // Handshake: none. A branch result is taken in any cycle br_valid=1; a commit is taken
  // in any cycle rob_commit_valid=1. Neither side can be stalled.

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_FLUSH = 2'd2
  } state_e;

  state_e                 state_q;
  logic [ROB_IDX_W-1:0]   held_id_q;
  logic [31:0]            held_tgt_q;
  logic                   flush_q;
  logic [31:0]            redirect_pc_q;
  logic                   pending_q;
  logic                   upd_valid_q;
  logic [31:0]            upd_pc_q;
  logic                   upd_taken_q;
  logic [31:0]            upd_target_q;

  logic                   mispredict;
  logic                   held_commit;
  logic [ROB_IDX_W-1:0]   age_new;
  logic [ROB_IDX_W-1:0]   age_held;
  logic                   new_is_older;

  // Age relative to the ROB head; ROB_DEPTH is a power of two so the natural wrap is the modulo.
  assign age_new      = br_rob_id - rob_head_id;
  assign age_held     = held_id_q - rob_head_id;
  assign new_is_older = (age_new < age_held);
  assign mispredict   = br_valid && br_miss_predict;
  assign held_commit  = rob_commit_valid && (rob_head_id == held_id_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      held_id_q     <= '0;
      held_tgt_q    <= '0;
      flush_q       <= 1'b0;
      redirect_pc_q <= '0;
      pending_q     <= 1'b0;
      upd_valid_q   <= 1'b0;
      upd_pc_q      <= '0;
      upd_taken_q   <= 1'b0;
      upd_target_q  <= '0;
    end else begin
      flush_q     <= 1'b0;
      upd_valid_q <= 1'b0;

      // Results arriving during FLUSH belong to the squashed path and are dropped.
      if (br_valid && (state_q != S_FLUSH)) begin
        upd_valid_q  <= 1'b1;
        upd_pc_q     <= br_pc;
        upd_taken_q  <= br_taken;
        upd_target_q <= br_target_address;
      end

      case (state_q)
        S_IDLE: begin
          if (mispredict) begin
            held_id_q  <= br_rob_id;
            held_tgt_q <= br_target_address;
            pending_q  <= 1'b1;
            state_q    <= S_WAIT;
          end
        end
        S_WAIT: begin
          // Commit wins over a same-cycle mispredict, which is necessarily younger.
          if (held_commit) begin
            flush_q       <= 1'b1;
            redirect_pc_q <= held_tgt_q;
            pending_q     <= 1'b0;
            held_id_q     <= '0;
            held_tgt_q    <= '0;
            state_q       <= S_FLUSH;
          end else if (mispredict && new_is_older) begin
            held_id_q  <= br_rob_id;
            held_tgt_q <= br_target_address;
          end
        end
        S_FLUSH: begin
          state_q <= S_IDLE;
        end
        default: begin
          pending_q <= 1'b0;
          state_q   <= S_IDLE;
        end
      endcase
    end
  end

  assign flush       = flush_q;
  assign redirect_pc = redirect_pc_q;
  assign pending     = pending_q;
  assign upd_valid   = upd_valid_q;
  assign upd_pc      = upd_pc_q;
  assign upd_taken   = upd_taken_q;
  assign upd_target  = upd_target_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_br_redirect.sv
// Directed bench for br_redirect: drivers push expected flush/update events tagged with
// the cycle they must appear in; a negedge monitor pops and compares them.
module tb_br_redirect;

  logic        clk = 1'b0;
  logic        rst;
  logic        br_valid;
  logic [3:0]  br_rob_id;
  logic        br_miss_predict;
  logic [31:0] br_target_address;
  logic [31:0] br_pc;
  logic        br_taken;
  logic [3:0]  rob_head_id;
  logic        rob_commit_valid;
  logic        flush;
  logic [31:0] redirect_pc;
  logic        pending;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic [1:0]  dbg_state;

  br_redirect #(.ROB_DEPTH(16)) dut (
    .clk               (clk),
    .rst               (rst),
    .br_valid          (br_valid),
    .br_rob_id         (br_rob_id),
    .br_miss_predict   (br_miss_predict),
    .br_target_address (br_target_address),
    .br_pc             (br_pc),
    .br_taken          (br_taken),
    .rob_head_id       (rob_head_id),
    .rob_commit_valid  (rob_commit_valid),
    .flush             (flush),
    .redirect_pc       (redirect_pc),
    .pending           (pending),
    .upd_valid         (upd_valid),
    .upd_pc            (upd_pc),
    .upd_taken         (upd_taken),
    .upd_target        (upd_target),
    .dbg_state         (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;

  // upd entry: {cycle[31:0], pc[31:0], taken, target[31:0]}; flush entry: {cycle[31:0], pc[31:0]}
  logic [96:0] upd_exp_q[$];
  logic [63:0] flush_exp_q[$];
  logic [96:0] ue;
  logic [63:0] fe;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (upd_valid === 1'b1) begin
      if (upd_exp_q.size() == 0 || upd_exp_q[0][96:65] != cyc) begin
        chk("upd_valid_unexpected", {31'b0, upd_valid}, 32'd0);
      end else begin
        ue = upd_exp_q.pop_front();
        chk("upd_pc", upd_pc, ue[64:33]);
        chk("upd_taken", {31'b0, upd_taken}, {31'b0, ue[32]});
        chk("upd_target", upd_target, ue[31:0]);
      end
    end else if (upd_exp_q.size() > 0 && upd_exp_q[0][96:65] == cyc) begin
      void'(upd_exp_q.pop_front());
      chk("upd_valid_missing", {31'b0, upd_valid}, 32'd1);
    end

    if (flush === 1'b1) begin
      if (flush_exp_q.size() == 0 || flush_exp_q[0][63:32] != cyc) begin
        chk("flush_unexpected", {31'b0, flush}, 32'd0);
      end else begin
        fe = flush_exp_q.pop_front();
        chk("redirect_pc", redirect_pc, fe[31:0]);
      end
    end else if (flush_exp_q.size() > 0 && flush_exp_q[0][63:32] == cyc) begin
      void'(flush_exp_q.pop_front());
      chk("flush_missing", {31'b0, flush}, 32'd1);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
    br_valid         = 1'b0;
    br_miss_predict  = 1'b0;
    rob_commit_valid = 1'b0;
  endtask

  task automatic br(input logic [3:0] id, input logic miss, input logic [31:0] pc,
                    input logic taken, input logic [31:0] tgt, input bit exp_upd);
    logic [31:0] c;
    br_valid          = 1'b1;
    br_rob_id         = id;
    br_miss_predict   = miss;
    br_pc             = pc;
    br_taken          = taken;
    br_target_address = tgt;
    c = cyc + 1;
    if (exp_upd) upd_exp_q.push_back({c, pc, taken, tgt});
  endtask

  task automatic commit(input logic [3:0] head);
    rob_head_id      = head;
    rob_commit_valid = 1'b1;
  endtask

  task automatic exp_flush(input logic [31:0] pc);
    logic [31:0] c;
    c = cyc + 1;
    flush_exp_q.push_back({c, pc});
  endtask

  task automatic chk_pending(input logic exp);
    chk("pending", {31'b0, pending}, {31'b0, exp});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst               = 1'b1;
    br_valid          = 1'b0;
    br_rob_id         = '0;
    br_miss_predict   = 1'b0;
    br_target_address = '0;
    br_pc             = '0;
    br_taken          = 1'b0;
    rob_head_id       = '0;
    rob_commit_valid  = 1'b0;
    step();
    step();
    chk("reset_redirect_pc", redirect_pc, 32'd0);
    chk("reset_upd_pc", upd_pc, 32'd0);
    chk("reset_upd_target", upd_target, 32'd0);
    rst = 1'b0;

    // Idle after reset
    for (int i = 0; i < 5; i++) begin
      step();
      chk_pending(1'b0);
    end

    // Correct prediction: update only
    br(4'd3, 1'b0, 32'h100, 1'b1, 32'h200, 1'b1);
    step(); chk_pending(1'b0);
    step(); chk_pending(1'b0);

    // Basic mispredict, commit 0,1,2
    rob_head_id = 4'd0;
    br(4'd2, 1'b1, 32'h110, 1'b1, 32'h0000_ffff, 1'b1);
    step(); chk_pending(1'b1);
    commit(4'd0); step(); chk_pending(1'b1);
    commit(4'd1); step(); chk_pending(1'b1);
    commit(4'd2); exp_flush(32'h0000_ffff);
    step(); chk_pending(1'b0);
    step(); chk_pending(1'b0);

    // Older replaces younger; equal and younger ignored
    rob_head_id = 4'd0;
    br(4'd5, 1'b1, 32'h150, 1'b0, 32'h500, 1'b1);
    step(); chk_pending(1'b1);
    br(4'd3, 1'b1, 32'h130, 1'b1, 32'h300, 1'b1);
    step();
    br(4'd3, 1'b1, 32'h131, 1'b0, 32'h333, 1'b1);
    step();
    br(4'd7, 1'b1, 32'h170, 1'b1, 32'h700, 1'b1);
    step();
    commit(4'd0); step();
    commit(4'd1); step();
    commit(4'd2); step(); chk_pending(1'b1);
    commit(4'd3); exp_flush(32'h300);
    step(); chk_pending(1'b0);
    commit(4'd4); step();
    commit(4'd5); step(); chk_pending(1'b0);

    // Wrap-around: head=14, held 1 replaced by 15
    rob_head_id = 4'd14;
    br(4'd1, 1'b1, 32'h1c0, 1'b1, 32'h40, 1'b1);
    step(); chk_pending(1'b1);
    br(4'd15, 1'b1, 32'h1f0, 1'b0, 32'h80, 1'b1);
    step();
    commit(4'd14); step(); chk_pending(1'b1);
    commit(4'd15); exp_flush(32'h80);
    step(); chk_pending(1'b0);
    commit(4'd0); step();
    commit(4'd1); step(); chk_pending(1'b0);

    // Simultaneous commit of held id and a new mispredict
    rob_head_id = 4'd4;
    br(4'd4, 1'b1, 32'h240, 1'b1, 32'h444, 1'b1);
    step(); chk_pending(1'b1);
    commit(4'd4);
    br(4'd6, 1'b1, 32'h260, 1'b0, 32'h666, 1'b1);
    exp_flush(32'h444);
    step(); chk_pending(1'b0);
    br(4'd8, 1'b1, 32'h280, 1'b1, 32'h888, 1'b0);
    step(); chk_pending(1'b0);
    step(); chk_pending(1'b0);

    // Reset during WAIT drops the held entry
    rob_head_id = 4'd0;
    br(4'd9, 1'b1, 32'h290, 1'b1, 32'h999, 1'b1);
    step(); chk_pending(1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_pending(1'b0);
    commit(4'd9); step(); chk_pending(1'b0);
    step(); chk_pending(1'b0);

    repeat (3) step();
    chk("upd_queue_left", upd_exp_q.size(), 32'd0);
    chk("flush_queue_left", flush_exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
